// File: rtl/riscv_data_memory.sv
// -----------------------------------------------------------------------------
// riscv_data_memory
//
// Byte-addressable, little-endian RV32 data memory for the core's load/store
// port. Loads are zero-wait-state (purely combinational on the byte array)
// with RV32I sign/zero extension chosen by funct3. Stores of 1/2/4 bytes are
// captured on the rising clock edge. Addresses wrap modulo DEPTH_BYTES and
// there is no alignment restriction: every access is split into byte lanes,
// lane k sitting at (addr + k) mod DEPTH_BYTES.
//
// Parameters:
//   DEPTH_BYTES : storage size in bytes (power of two, >= 4)
//
// Ports:
//   clk        in   1  : clock, all writes on its rising edge
//   rst_n      in   1  : asynchronous active-low reset (clears array)
//   addr       in  32  : byte address, low log2(DEPTH_BYTES) bits used
//   write_data in  32  : store data, low 8/16/32 bits used per funct3
//   mem_write  in   1  : store enable, sampled on the rising edge
//   mem_read   in   1  : load enable, combinational
//   funct3     in   3  : RV32I load/store width/sign code
//   read_data  out 32  : extended load result, combinational
//   mem_ready  out  1  : registered "memory available" flag
// -----------------------------------------------------------------------------
module riscv_data_memory #(
   parameter int DEPTH_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [2:0]  funct3,
   output logic [31:0] read_data,
   output logic        mem_ready
);

   localparam int AW = $clog2(DEPTH_BYTES);

   // RV32I load/store width codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [7:0]    mem_q [DEPTH_BYTES];
   logic          mem_ready_q;
   logic          mem_ready_d;

   logic [AW-1:0] lane_addr_s [4];
   logic [3:0]    lane_we_d;
   logic [7:0]    lane_data_d [4];
   logic [7:0]    rd_byte_s [4];
   logic [31:0]   rd_word_s;
   logic [31:0]   read_data_s;

   // Upper address bits are ignored by design (addresses alias modulo depth).
   logic          unused_addr_s;
   assign unused_addr_s = ^addr[31:AW];

   // Byte-lane addresses: lane k sits at (addr + k) mod DEPTH_BYTES. The
   // AW-bit addition provides the wrap from the top of memory to byte 0.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane_addr_s[k] = addr[AW-1:0] + AW'(k);
      end
   end

   // Store lane enables and data: SB/SH/SW enable 1/2/4 low lanes, any other
   // funct3 writes nothing.
   always_comb begin
      lane_we_d = 4'b0000;
      if (mem_write) begin
         case (funct3)
            F3_B:    lane_we_d = 4'b0001;
            F3_H:    lane_we_d = 4'b0011;
            F3_W:    lane_we_d = 4'b1111;
            default: lane_we_d = 4'b0000;
         endcase
      end else begin
         lane_we_d = 4'b0000;
      end
      for (int k = 0; k < 4; k++) begin
         lane_data_d[k] = write_data[8*k +: 8];
      end
   end

   // Ready flag goes high on the first edge out of reset and stays high.
   always_comb begin
      mem_ready_d = 1'b1;
   end

   // Byte array and ready flag. Reset clears every byte asynchronously, so a
   // store pending when reset asserts is discarded. Lane addresses are always
   // distinct because DEPTH_BYTES >= 4, so the four lane writes never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem_q[i] <= 8'h00;
         end
         mem_ready_q <= 1'b0;
      end else begin
         mem_ready_q <= mem_ready_d;
         for (int k = 0; k < 4; k++) begin
            if (lane_we_d[k]) begin
               mem_q[lane_addr_s[k]] <= lane_data_d[k];
            end
         end
      end
   end

   // Combinational byte fetch for all four lanes, assembled little-endian.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_byte_s[k] = mem_q[lane_addr_s[k]];
      end
      rd_word_s = {rd_byte_s[3], rd_byte_s[2], rd_byte_s[1], rd_byte_s[0]};
   end

   // Load extension by funct3; disabled or unsupported loads return zero.
   always_comb begin
      read_data_s = 32'h0000_0000;
      if (mem_read) begin
         case (funct3)
            F3_B:    read_data_s = {{24{rd_word_s[7]}},  rd_word_s[7:0]};
            F3_H:    read_data_s = {{16{rd_word_s[15]}}, rd_word_s[15:0]};
            F3_W:    read_data_s = rd_word_s;
            F3_BU:   read_data_s = {24'h00_0000, rd_word_s[7:0]};
            F3_HU:   read_data_s = {16'h0000, rd_word_s[15:0]};
            default: read_data_s = 32'h0000_0000;
         endcase
      end else begin
         read_data_s = 32'h0000_0000;
      end
   end

   assign read_data = read_data_s;
   assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_riscv_data_memory.sv
// -----------------------------------------------------------------------------
// tb_riscv_data_memory
//
// Self-checking bench for riscv_data_memory. A byte-array model tracks what
// the memory must hold; a compare process checks read_data and mem_ready
// against it on every falling edge, and directed scenarios check literal
// expected values against both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_riscv_data_memory;

   localparam int D = 4096;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        mem_ready;

   int vectors;
   int miscompares;

   logic [7:0] m_mem [D];
   logic       m_ready;

   riscv_data_memory #(.DEPTH_BYTES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .write_data (write_data),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .funct3     (funct3),
      .read_data  (read_data),
      .mem_ready  (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a plain byte array updated from the store rules.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) m_mem[i] <= 8'h00;
         m_ready <= 1'b0;
      end else begin
         int nbytes;
         nbytes = (funct3 == F_B) ? 1 : (funct3 == F_H) ? 2 : (funct3 == F_W) ? 4 : 0;
         m_ready <= 1'b1;
         if (mem_write) begin
            for (int k = 0; k < 4; k++) begin
               if (k < nbytes)
                  m_mem[(addr + 32'(k)) % 32'(D)] <= 8'(write_data >> (8 * k));
            end
         end
      end
   end

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3,
                                              input logic rd);
      logic [31:0] w;
      logic [31:0] b;
      logic [31:0] h;
      w = 32'd0;
      for (int k = 0; k < 4; k++)
         w = w | (32'(m_mem[(a + 32'(k)) % 32'(D)]) << (8 * k));
      b = w & 32'h0000_00FF;
      h = w & 32'h0000_FFFF;
      if (!rd) return 32'd0;
      case (f3)
         F_B:     return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         F_H:     return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         F_W:     return w;
         F_BU:    return b;
         F_HU:    return h;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle compare of DUT outputs against the model.
   always @(negedge clk) begin
      check("cyc_read_data", read_data, model_load(addr, funct3, mem_read));
      check("cyc_mem_ready", 32'(mem_ready), 32'(m_ready));
   end

   // Apply a load and check DUT and model against a hand-computed value.
   task automatic expect_load(input string name, input logic [31:0] a, input logic [2:0] f3,
                              input logic rd, input logic [31:0] exp);
      mem_write = 1'b0;
      addr      = a;
      funct3    = f3;
      mem_read  = rd;
      #1;
      check(name, read_data, exp);
      check({"model_", name}, model_load(a, f3, rd), exp);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      @(posedge clk);
      #2;
      addr       = a;
      write_data = d;
      funct3     = f3;
      mem_write  = 1'b1;
      mem_read   = 1'b0;
      @(posedge clk);
      #2;
      mem_write  = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      addr        = 32'd0;
      write_data  = 32'd0;
      mem_write   = 1'b0;
      mem_read    = 1'b0;
      funct3      = 3'b000;
      rst_n       = 1'b1;
      #1 rst_n    = 1'b0;

      // Reset
      #21;
      check("ready_in_reset", 32'(mem_ready), 32'd0);
      rst_n = 1'b1;
      #1 check("ready_before_edge", 32'(mem_ready), 32'd0);
      @(posedge clk);
      #1 check("ready_after_edge", 32'(mem_ready), 32'd1);
      expect_load("rst_lw_0",     32'h0000_0000,  F_W, 1'b1, 32'h0000_0000);
      expect_load("rst_lw_100",   32'h0000_0100,  F_W, 1'b1, 32'h0000_0000);
      expect_load("rst_lw_top",   32'(D - 4),     F_W, 1'b1, 32'h0000_0000);

      // Word round-trip
      store(32'h10, 32'hDEAD_BEEF, F_W);
      expect_load("rt_lw",    32'h10, F_W,  1'b1, 32'hDEAD_BEEF);
      expect_load("rt_lbu10", 32'h10, F_BU, 1'b1, 32'h0000_00EF);
      expect_load("rt_lbu13", 32'h13, F_BU, 1'b1, 32'h0000_00DE);
      expect_load("rt_lh12",  32'h12, F_H,  1'b1, 32'hFFFF_DEAD);
      expect_load("rt_lhu12", 32'h12, F_HU, 1'b1, 32'h0000_DEAD);
      expect_load("rt_lb13",  32'h13, F_B,  1'b1, 32'hFFFF_FFDE);

      // Partial stores
      store(32'h20, 32'h1122_3344, F_W);
      store(32'h21, 32'hFFFF_FFAB, F_B);
      expect_load("sb_lw", 32'h20, F_W, 1'b1, 32'h1122_AB44);
      store(32'h22, 32'hFFFF_7788, F_H);
      expect_load("sh_lw", 32'h20, F_W, 1'b1, 32'h7788_AB44);

      // Wrap and misalignment
      store(32'(D - 2), 32'hA1B2_C3D4, F_W);
      expect_load("wrap_lhu_top", 32'(D - 2),     F_HU, 1'b1, 32'h0000_C3D4);
      expect_load("wrap_lhu_0",   32'h0,          F_HU, 1'b1, 32'h0000_A1B2);
      expect_load("wrap_lw_alias", 32'(2 * D - 2), F_W, 1'b1, 32'hA1B2_C3D4);

      // Illegal and disabled accesses
      store(32'h30, 32'hFFFF_FFFF, 3'b011);
      expect_load("ill_store_lw", 32'h30, F_W,    1'b1, 32'h0000_0000);
      expect_load("ill_load_110", 32'h10, 3'b110, 1'b1, 32'h0000_0000);
      expect_load("rd_disabled",  32'h10, F_W,    1'b0, 32'h0000_0000);

      // Simultaneous read and write to the same address
      @(posedge clk);
      #2;
      addr       = 32'h10;
      funct3     = F_W;
      write_data = 32'h0000_0055;
      mem_read   = 1'b1;
      mem_write  = 1'b1;
      #1 check("rw_before_edge", read_data, 32'hDEAD_BEEF);
      @(posedge clk);
      #1 check("rw_after_edge", read_data, 32'h0000_0055);
      #1 mem_write = 1'b0;

      // Back-to-back byte stores on consecutive edges
      @(posedge clk);
      #2;
      funct3     = F_B;
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      addr       = 32'h50;
      write_data = 32'h0000_0001;
      @(posedge clk);
      #2;
      addr       = 32'h51;
      write_data = 32'h0000_0002;
      @(posedge clk);
      #2;
      addr       = 32'h52;
      write_data = 32'h0000_0003;
      @(posedge clk);
      #2;
      mem_write  = 1'b0;
      expect_load("b2b_lw", 32'h50, F_W, 1'b1, 32'h0003_0201);

      // Reset asserted while a store is pending
      @(posedge clk);
      #2;
      addr       = 32'h40;
      write_data = 32'h1234_5678;
      funct3     = F_W;
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      #4 rst_n   = 1'b0;
      @(posedge clk);
      #2;
      mem_write  = 1'b0;
      check("mid_ready_in_reset", 32'(mem_ready), 32'd0);
      @(posedge clk);
      #2 rst_n   = 1'b1;
      #1 check("mid_ready_before_edge", 32'(mem_ready), 32'd0);
      @(posedge clk);
      #1 check("mid_ready_after_edge", 32'(mem_ready), 32'd1);
      expect_load("mid_lw_40", 32'h40, F_W, 1'b1, 32'h0000_0000);
      expect_load("mid_lw_20", 32'h20, F_W, 1'b1, 32'h0000_0000);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_data_memory.md
# riscv_data_memory

Byte-addressable, little-endian RV32 data memory serving the CPU core's load/store port. It provides zero-wait-state combinational loads with RV32I sign/zero extension selected by `funct3`, and synchronous byte/half/word stores. It sits beside `cpu_top` in the top-level system. `cpu_top` has no ready input, so every access must complete with no stall.

## Interface
Parameters:
- `DEPTH_BYTES`, default 4096: storage size in bytes. Must be a power of two, at least 4.

Ports:
- `clk`  in  1: single clock; all writes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `addr`  in  32: byte address; only the low log2(DEPTH_BYTES) bits are used.
- `write_data`  in  32: store data; the low 8/16/32 bits are used per `funct3`.
- `mem_write`  in  1: store enable, sampled on the clk rising edge.
- `mem_read`  in  1: load enable, combinational.
- `funct3`  in  3: RV32I load/store width/sign code.
- `read_data`  out  32: extended load result, combinational.
- `mem_ready`  out  1: memory available; registered.

## Operation
- Storage is DEPTH_BYTES bytes, little-endian.
  - Byte k of an access is at (addr + k) mod DEPTH_BYTES.
  - A multi-byte access crossing the top wraps to byte 0.
  - No alignment requirement; misaligned accesses are performed byte-wise.
- Loads apply when `mem_read`=1:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other `funct3`: `read_data`=0.
- When `mem_read`=0, `read_data`=0.
- Stores apply when `mem_write`=1 and `rst_n`=1, on the rising edge:
  - 000 SB: write 1 byte.
  - 001 SH: write 2 bytes.
  - 010 SW: write 4 bytes.
  - Other `funct3`: no write.
- Untouched bytes keep their value.
- Simultaneous `mem_read` and `mem_write` to the same address:
  - Before the edge, `read_data` shows the old contents.
  - After the edge it shows the new contents, since the read is combinational on the array.
- Reset (`rst_n`=0, asynchronous):
  - All bytes clear to 0x00.
  - `mem_ready`=0.
  - Stores are ignored while reset is held, including a write pending at the time reset asserts.
  - `read_data` still follows the combinational rules, so it returns 0 while the array is cleared.
- `mem_ready`:
  - Flop cleared by reset.
  - Set to 1 on the first rising edge with `rst_n`=1.
  - Stays 1 thereafter.
  - It is informational only; no request or handshake is required.

## Timing
- Load latency 0 cycles: `read_data` is a pure combinational function of `addr`, `funct3`, `mem_read` and the array.
- Store latency 1 edge: new data is visible combinationally immediately after the capturing rising edge.
- Back-to-back stores every cycle are supported; there is no throughput limit.
- Reset values:
  - `mem_ready`=0.
  - `read_data`=0 (array is zero).
  - All array bytes = 0x00.
- Reset release: `mem_ready` rises at the first clk rising edge after `rst_n` goes high. Stores are accepted from that same edge.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n`=0 for 20 ns, then release.
  - Required: `mem_ready`=0 during reset and 1 after the first edge post-release.
  - Required: LW of 0x0, 0x100 and DEPTH_BYTES-4 all return 0x00000000.
- **Word round-trip:**
  - Stimulus: SW 0xDEADBEEF at 0x10.
  - Required: LW=0xDEADBEEF, LBU at 0x10 = 0x000000EF, LBU at 0x13 = 0x000000DE.
  - Required: LH at 0x12 = 0xFFFFDEAD, LHU at 0x12 = 0x0000DEAD, LB at 0x13 = 0xFFFFFFDE.
- **Partial stores:**
  - Stimulus: after SW 0x11223344 at 0x20, SB 0xAB at 0x21 (`write_data` 0xFFFFFFAB).
  - Required: LW at 0x20 = 0x1122AB44.
  - Stimulus: then SH 0x7788 at 0x22.
  - Required: LW at 0x20 = 0x7788AB44.
- **Wrap and misalignment:**
  - Stimulus: SW 0xA1B2C3D4 at DEPTH_BYTES-2.
  - Required: LHU at DEPTH_BYTES-2 = 0x0000C3D4, LHU at 0x0 = 0x0000A1B2.
  - Required: LW at addr = DEPTH_BYTES+DEPTH_BYTES-2 gives the same 0xA1B2C3D4.
- **Illegal and disabled accesses:**
  - Stimulus: `funct3`=011 store of 0xFFFFFFFF at 0x30.
  - Required: memory is unchanged (LW = 0).
  - Required: `funct3`=110 load returns 0.
  - Required: `mem_read`=0 forces `read_data`=0 whatever is at the address.
- **Reset mid-operation:**
  - Stimulus: with `mem_write`=1 (SW 0x12345678 at 0x40), assert `rst_n`=0 before the edge and hold across it.
  - Required: after release, LW at 0x40 = 0 and `mem_ready` re-rises one edge after release.
